// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder stage: FSM states and
// output word builders.
package rle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Word builders work on this width; callers cast to their own DW.
    localparam int unsigned MAX_DW   = 64;
    localparam int unsigned CNTW_DEF = 16;
    localparam int unsigned CNT_MAX  = 2**CNTW_DEF - 1;

    function automatic int unsigned cnt_max(input int unsigned cntw);
        return (32'd1 << cntw) - 32'd1;
    endfunction

    function automatic logic [MAX_DW-1:0] value_word(input logic [MAX_DW-1:0] m,
                                                     input int unsigned       dw);
        return m & ~(MAX_DW'(1) << (dw - 1));
    endfunction

    function automatic logic [MAX_DW-1:0] count_word(input logic [MAX_DW-1:0] cnt,
                                                     input int unsigned       dw);
        return cnt | (MAX_DW'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/str_reg.sv
// One-entry stream register: loads a word, holds it while the sink stalls,
// and drains it on a valid/ready transfer.
module str_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // The owner only asserts i_load when the entry is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/rle_enc.sv
// Run-length encoder: emits a value word per new masked sample and a flagged
// count word for repeats; transparent bypass when disabled and idle.
module rle_enc
    import rle_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_ena,
    input  logic          ctl_clr,
    input  logic [DW-1:0] cfg_mask,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic          sto_valid,
    input  logic          sto_ready
);

    localparam logic [CNTW-1:0] C_LAST     = CNTW'(cnt_max(CNTW) - 1);
    localparam logic [DW-1:0]   C_SMASK    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   C_SAT_WORD = DW'(count_word(MAX_DW'(cnt_max(CNTW)), DW));

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_hold, w_hold_nx;
    logic [DW-1:0]   r_pend, w_pend_nx;
    logic [CNTW-1:0] r_cnt, w_cnt_nx;
    logic            r_clr_pend, w_clr_pend_nx;

    logic            w_load;
    logic [DW-1:0]   w_load_data;
    logic            w_out_valid;
    logic [DW-1:0]   w_out_data;
    logic [DW-1:0]   w_m;
    logic [DW-1:0]   w_val_m, w_val_pend, w_cnt_word;
    logic            w_free, w_clr, w_bypass, w_enc_ready, w_acc;

    assign w_m        = sti_data & cfg_mask & C_SMASK;
    assign w_val_m    = DW'(value_word(MAX_DW'(w_m), DW));
    assign w_val_pend = DW'(value_word(MAX_DW'(r_pend), DW));
    assign w_cnt_word = DW'(count_word(MAX_DW'(r_cnt), DW));

    assign w_free = !w_out_valid || sto_ready;
    // Any state other than IDLE is only reachable with ctl_ena high, so a low
    // level there means the enable has fallen and the run must be closed.
    assign w_clr       = ctl_clr || r_clr_pend || (!ctl_ena && r_state != IDLE);
    assign w_bypass    = !ctl_ena && r_state == IDLE && !w_out_valid;
    assign w_enc_ready = ctl_ena && r_state != FLUSH && w_free && !w_clr;
    assign w_acc       = sti_valid && w_enc_ready;

    assign sti_ready = w_bypass ? sto_ready : w_enc_ready;
    assign sto_valid = w_bypass ? sti_valid : w_out_valid;
    assign sto_data  = w_bypass ? sti_data  : w_out_data;

    always_comb begin
        w_state_nx    = r_state;
        w_hold_nx     = r_hold;
        w_pend_nx     = r_pend;
        w_cnt_nx      = r_cnt;
        w_clr_pend_nx = r_clr_pend;
        w_load        = 1'b0;
        w_load_data   = '0;
        case (r_state)
            IDLE: begin
                w_clr_pend_nx = 1'b0;
                if (w_acc) begin
                    w_load      = 1'b1;
                    w_load_data = w_val_m;
                    w_hold_nx   = w_m;
                    w_cnt_nx    = '0;
                    w_state_nx  = RUN;
                end
            end
            RUN: begin
                if (w_clr) begin
                    if (r_cnt == '0) begin
                        w_clr_pend_nx = 1'b0;
                        w_state_nx    = IDLE;
                    end else if (w_free) begin
                        w_load        = 1'b1;
                        w_load_data   = w_cnt_word;
                        w_cnt_nx      = '0;
                        w_clr_pend_nx = 1'b0;
                        w_state_nx    = IDLE;
                    end else begin
                        w_clr_pend_nx = 1'b1;
                    end
                end else if (w_acc) begin
                    if (w_m == r_hold) begin
                        if (r_cnt == C_LAST) begin
                            w_load      = 1'b1;
                            w_load_data = C_SAT_WORD;
                            w_cnt_nx    = '0;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end else if (r_cnt == '0) begin
                        w_load      = 1'b1;
                        w_load_data = w_val_m;
                        w_hold_nx   = w_m;
                    end else begin
                        w_load      = 1'b1;
                        w_load_data = w_cnt_word;
                        w_pend_nx   = w_m;
                        w_state_nx  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_clr) begin
                    w_clr_pend_nx = 1'b1;
                end
                if (w_free) begin
                    w_load        = 1'b1;
                    w_load_data   = w_val_pend;
                    w_hold_nx     = r_pend;
                    w_cnt_nx      = '0;
                    w_clr_pend_nx = 1'b0;
                    w_state_nx    = w_clr ? IDLE : RUN;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hold     <= w_hold_nx;
            r_pend     <= w_pend_nx;
            r_cnt      <= w_cnt_nx;
            r_clr_pend <= w_clr_pend_nx;
        end
    end

    str_reg #(
        .W (DW)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (sto_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

endmodule

// File: tb/tb_rle_enc.sv
// Randomised self-checking bench for rle_enc against a run-grouping
// reference model; small counter width so saturation occurs often.
module tb_rle_enc;

    localparam int unsigned DW   = 32;
    localparam int unsigned CNTW = 4;
    localparam int          CMAX = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        rst, ctl_ena, ctl_clr, sti_valid, sti_ready, sto_valid, sto_ready;
    logic [31:0] cfg_mask, sti_data, sto_data;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    bit          bp_on   = 1'b0;
    bit          stab_en = 1'b0;
    bit          byp_chk = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] dq[$];

    rle_enc #(
        .DW   (DW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_ena   (ctl_ena),
        .ctl_clr   (ctl_clr),
        .cfg_mask  (cfg_mask),
        .sti_data  (sti_data),
        .sti_valid (sti_valid),
        .sti_ready (sti_ready),
        .sto_data  (sto_data),
        .sto_valid (sto_valid),
        .sto_ready (sto_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Output monitor: collects transfers, checks hold-while-stalled and bypass.
    always @(negedge clk) begin
        if (stab_en && prev_stall) begin
            chk("stall_valid", 32'(sto_valid), 32'd1);
            chk("stall_data", sto_data, prev_data);
        end
        if (byp_chk && sti_valid) begin
            chk("byp_valid", 32'(sto_valid), 32'd1);
            chk("byp_data", sto_data, sti_data);
        end
        prev_stall = sto_valid && !sto_ready;
        prev_data  = sto_data;
        if (sto_valid && sto_ready) got_q.push_back(sto_data);
    end

    initial begin
        sto_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sto_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        n         = 0;
        sti_data  = d;
        sti_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sti_ready) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        sti_valid = 1'b0;
    endtask

    // Reference: group masked samples into runs; each run is a value word
    // followed by its repeat count split into chunks of at most CMAX.
    task automatic model_seg(input logic [31:0] s[$]);
        int i, len, rep;
        i = 0;
        while (i < s.size()) begin
            len = 1;
            while (i + len < s.size() && s[i+len] == s[i]) len++;
            exp_q.push_back({1'b0, s[i][30:0]});
            rep = len - 1;
            while (rep >= CMAX) begin
                exp_q.push_back(32'h8000_0000 | 32'(CMAX));
                rep -= CMAX;
            end
            if (rep > 0) exp_q.push_back(32'h8000_0000 | 32'(rep));
            i += len;
        end
    endtask

    task automatic compare_out(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        ctl_clr = 1'b1;
        @(posedge clk);
        #1;
        ctl_clr = 1'b0;
    endtask

    // Sends dq under cfg_mask, then closes the run by clr (end_ena=0) or by
    // dropping ctl_ena (end_ena=1) and compares against the model.
    task automatic run_seg(input logic [31:0] mask, input bit end_ena, input bit chk_flush,
                           input string tag);
        logic [31:0] mq[$];
        cfg_mask = mask;
        foreach (dq[i]) begin
            send(dq[i]);
            mq.push_back(dq[i] & mask & 32'h7FFF_FFFF);
        end
        if (chk_flush) begin
            @(negedge clk);
            chk("flush_ready", 32'(sti_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        model_seg(mq);
        if (end_ena) ctl_ena = 1'b0;
        else pulse_clr();
        compare_out(tag);
        ctl_ena = 1'b1;
        dq.delete();
    endtask

    initial begin
        logic [31:0] d, v, mask;
        logic [3:0]  nib;
        int unsigned t0;
        int          nruns, len;

        rst = 1'b1; ctl_ena = 1'b1; ctl_clr = 1'b0;
        cfg_mask = '1; sti_data = '0; sti_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 32'(sto_valid), 32'd0);
        chk("rst_data", sto_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(sti_ready), 32'd1);
        @(posedge clk);
        #1;
        stab_en = 1'b1;

        // Bypass: data passes through combinationally, back to back.
        ctl_ena = 1'b0;
        byp_chk = 1'b1;
        t0 = cyc;
        for (int unsigned i = 0; i < 16; i++) begin
            nib = 4'(i);
            d   = {8{nib}};
            exp_q.push_back(d);
            send(d);
        end
        chk("byp_cycles", cyc - t0, 32'd16);
        byp_chk = 1'b0;
        compare_out("byp");
        ctl_ena = 1'b1;

        repeat (3) dq.push_back(32'h1111_1111);
        dq.push_back(32'h2222_2222);
        run_seg(32'hFFFF_FFFF, 1'b0, 1'b1, "t2");

        repeat (20) dq.push_back(32'h0000_0005);
        run_seg(32'hFFFF_FFFF, 1'b0, 1'b0, "t3_sat");

        dq.push_back(32'h1234_5601);
        dq.push_back(32'hABCD_EF01);
        run_seg(32'h0000_00FF, 1'b0, 1'b0, "t4_mask");

        bp_on = 1'b1;
        repeat (2) dq.push_back(32'h0A0A_0A0A);
        repeat (3) dq.push_back(32'h0B0B_0B0B);
        dq.push_back(32'h0C0C_0C0C);
        run_seg(32'hFFFF_FFFF, 1'b0, 1'b0, "t5_bp");
        bp_on = 1'b0;

        // Reset mid-run discards the pending count.
        repeat (4) send(32'h0000_0033);
        stab_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_valid", 32'(sto_valid), 32'd0);
        repeat (10) @(negedge clk);
        exp_q.push_back(32'h0000_0033);
        compare_out("rst_pre");
        stab_en = 1'b1;
        dq.push_back(32'h0000_0033);
        run_seg(32'hFFFF_FFFF, 1'b0, 1'b0, "rst_post");

        for (int seg = 0; seg < 24; seg++) begin
            bp_on = 1'($urandom_range(0, 1));
            mask  = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
            nruns = $urandom_range(1, 6);
            v     = $urandom;
            for (int r = 0; r < nruns; r++) begin
                if (r == 0 || $urandom_range(0, 4) != 0) v = $urandom;
                len = $urandom_range(1, 35);
                for (int k = 0; k < len; k++)
                    dq.push_back(v ^ ($urandom & ~(mask & 32'h7FFF_FFFF)));
            end
            run_seg(mask, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
